// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtraction controller.
// The controller's FSM state encoding and the supported operand widths live here.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, built from two half-subtract stages.
// The top instantiates this cell once and feeds it from the LSBs of its shift registers.
module fs_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // First stage computes a - b; second stage subtracts the incoming borrow.
    assign d1   = a ^ b;
    assign b1   = ~a & b;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: one full-subtract cell reused LSB-first,
// wrapped in valid/ready handshakes on the operand and result sides.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   diff_sr;
    logic               brw;
    logic [CNT_W-1:0]   cnt;
    logic               a_msb;
    logic               b_msb;
    logic               cell_d;
    logic               cell_bout;
    logic               last_bit;

    fs_bit_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (state_q == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        start_ready  = (state_q == IDLE);
        busy         = (state_q != IDLE);
        result_valid = (state_q == DONE);
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_valid)  state_d = SHIFT;
                SHIFT:   if (last_bit)     state_d = DONE;
                DONE:    if (result_ready) state_d = IDLE;
                default:                   state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: datapath registers are plain flops, not memories, so all of them are reset to a known zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            brw     <= 1'b0;
            cnt     <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (!clear) begin
            if (state_q == IDLE && start_valid) begin
                a_sr  <= a;
                b_sr  <= b;
                brw   <= bin;
                cnt   <= '0;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end else if (state_q == SHIFT) begin
                a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
                brw     <= cell_bout;
                cnt     <= cnt + 1'b1;
                // The final cell output is the result MSB, so ovf can be formed here directly.
                if (last_bit) begin
                    diff <= {cell_d, diff_sr[WIDTH-1:1]};
                    bout <= cell_bout;
                    ovf  <= (a_msb != b_msb) && (cell_d != a_msb);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: stimulus pushes reference results, a monitor
// pops and compares them whenever the DUT presents a result.
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             busy;
    logic             result_valid;
    logic             result_ready = 1'b1;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        longint     hs;
    } exp_t;

    exp_t   q[$];
    int     passed = 0;
    int     total = 0;
    longint cyc = 0;
    logic   rv_prev = 1'b0;
    logic   rand_ready = 1'b0;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .bin          (bin),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .diff         (diff),
        .bout         (bout),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 result_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: integer arithmetic on the operands, sign rule on the wrapped difference.
    function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib,
                                   input logic ibi, input longint hs);
        exp_t m;
        int   d;
        d      = int'(ia) - int'(ib) - int'(ibi);
        m.diff = d[7:0];
        m.bout = (d < 0);
        m.ovf  = (ia[7] != ib[7]) && (m.diff[7] != ia[7]);
        m.hs   = hs;
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            rv_prev = 1'b0;
        end else begin
            if (result_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    if (!rv_prev) check("latency", cyc - q[0].hs, WIDTH);
                    check("diff", diff, q[0].diff);
                    check("bout", bout, q[0].bout);
                    check("ovf", ovf, q[0].ovf);
                end
            end
            if (clear && busy) begin
                if (q.size() != 0) void'(q.pop_front());
            end else if (result_valid && result_ready && q.size() != 0) begin
                void'(q.pop_front());
            end
            rv_prev = result_valid;
        end
    end

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibi);
        int n = 0;
        @(posedge clk); #1;
        a = ia; b = ib; bin = ibi; start_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (start_ready && !clear) break;
            n++;
            if (n > 50) begin
                check("start_timeout", 0, 1);
                break;
            end
        end
        q.push_back(model(ia, ib, ibi, cyc + 1));
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q.size() != 0 || busy); i++) @(negedge clk);
        check("drain_queue", q.size(), 0);
    endtask

    initial begin
        #12;
        check("reset_diff", diff, 0);
        check("reset_valid", result_valid, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_start_ready", start_ready, 1);

        issue(8'd5, 8'd3, 1'b0);      drain();
        issue(8'd3, 8'd5, 1'b0);      drain();
        issue(8'h80, 8'h01, 1'b0);    drain();
        issue(8'h00, 8'h00, 1'b1);    drain();
        issue(8'hFF, 8'hFF, 1'b1);    drain();
        issue(8'h7F, 8'hFF, 1'b0);    drain();

        // Result held in DONE: outputs frozen, starts refused.
        result_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b1);
        for (int i = 0; i < 20 && !result_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start_valid = 1'($urandom_range(0, 1));
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            check("hold_start_ready", start_ready, 0);
            check("hold_valid", result_valid, 1);
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        check("release_start_ready", start_ready, 1);
        check("release_valid", result_valid, 0);
        drain();

        // Abort on the third SHIFT cycle, then a normal op.
        issue(8'h11, 8'h22, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_valid", result_valid, 0);
        check("clear_queue", q.size(), 0);
        issue(8'hAA, 8'h55, 1'b0);    drain();

        // clear together with start in IDLE: start must not be taken.
        @(posedge clk); #1;
        clear = 1'b1; start_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; start_valid = 1'b0;
        check("clear_start_busy", busy, 0);

        // Async reset mid-SHIFT.
        issue(8'h9C, 8'h3B, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            issue(8'($urandom), 8'($urandom), 1'($urandom));
            drain();
        end
        rand_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
